// File: rtl/unidade_acesso_memoria_pkg.sv
// Shared types for the load/store unit:
// operation and state encodings, alignment helpers.
package pacote_memoria;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    OCIOSO    = 2'b00,
    LEITURA   = 2'b01,
    ESCRITA   = 2'b10,
    CONCLUIDO = 2'b11
  } estado_t;

  function automatic logic eh_escrita(op_t op);
    return op inside {OP_SW, OP_SH, OP_SB};
  endfunction

  function automatic logic eh_palavra(op_t op);
    return op inside {OP_LW, OP_SW};
  endfunction

  function automatic logic eh_meia(op_t op);
    return op inside {OP_LH, OP_LHU, OP_SH};
  endfunction

  function automatic logic desalinhado(
    op_t        op,
    logic [1:0] a
  );
    return (eh_palavra(op) && (a != 2'b00)) ||
           (eh_meia(op) && a[0]);
  endfunction

endpackage

// File: rtl/unidade_acesso_memoria_if.sv
// Processor-side request bus plus the
// word-wide data memory port.
interface unidade_acesso_memoria_if;

  logic        Iniciar;
  logic [2:0]  Operacao;
  logic [31:0] Endereco;
  logic [31:0] DadosEntrada;
  logic        Ocupado;
  logic        Pronto;
  logic [31:0] DadosSaida;
  logic        ErroAlinhamento;
  logic [31:0] MemEndereco;
  logic [31:0] MemDadosEscrita;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] MemDadosLidos;

  modport master (
    output Iniciar, Operacao, Endereco,
    output DadosEntrada, MemDadosLidos,
    input  Ocupado, Pronto, DadosSaida,
    input  ErroAlinhamento, MemEndereco,
    input  MemDadosEscrita, MemWrite, MemRead
  );

  modport slave (
    input  Iniciar, Operacao, Endereco,
    input  DadosEntrada, MemDadosLidos,
    output Ocupado, Pronto, DadosSaida,
    output ErroAlinhamento, MemEndereco,
    output MemDadosEscrita, MemWrite, MemRead
  );

endinterface

// File: rtl/unidade_acesso_memoria_alinhador_bytes.sv
// Lane extraction with extension for loads and
// lane merge into a read word for sub-word stores.
module alinhador_bytes
  import pacote_memoria::*;
(
  input  op_t         op_i,
  input  logic [1:0]  desloc_i,
  input  logic [31:0] palavra_i,
  input  logic [15:0] dados_i,
  output logic [31:0] carga_o,
  output logic [31:0] mescla_o
);

  logic [4:0]  idx_b;
  logic [4:0]  idx_h;
  logic [7:0]  byte_sel;
  logic [15:0] meia_sel;

  // little-endian lane select and extension/merge
  always_comb begin
    idx_b    = {desloc_i, 3'b000};
    idx_h    = {desloc_i[1], 4'b0000};
    byte_sel = palavra_i[idx_b +: 8];
    meia_sel = palavra_i[idx_h +: 16];
    case (op_i)
      OP_LH:   carga_o = {{16{meia_sel[15]}}, meia_sel};
      OP_LHU:  carga_o = {16'h0000, meia_sel};
      OP_LB:   carga_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  carga_o = {24'h000000, byte_sel};
      default: carga_o = palavra_i;
    endcase
    mescla_o = palavra_i;
    if (op_i == OP_SH)
      mescla_o[idx_h +: 16] = dados_i;
    else if (op_i == OP_SB)
      mescla_o[idx_b +: 8] = dados_i[7:0];
  end

endmodule

// File: rtl/unidade_acesso_memoria.sv
// Load/store initiator: one request at a time,
// sub-word stores done as read-modify-write.
module unidade_acesso_memoria
  import pacote_memoria::*;
(
  input  logic Clock,
  input  logic ResetN,
  unidade_acesso_memoria_if.slave bus
);

  estado_t     estado_q, estado_d;
  op_t         op_q, op_d;
  logic [31:0] end_q, end_d;
  logic [15:0] dados_q, dados_d;
  logic [31:0] escrita_q, escrita_d;
  logic [31:0] saida_q, saida_d;
  logic        erro_q, erro_d;
  logic [31:0] carga;
  logic [31:0] mescla;
  op_t         op_in;

  assign op_in = op_t'(bus.Operacao);

  alinhador_bytes u_alinhador (
    .op_i      (op_q),
    .desloc_i  (end_q[1:0]),
    .palavra_i (bus.MemDadosLidos),
    .dados_i   (dados_q),
    .carga_o   (carga),
    .mescla_o  (mescla)
  );

  // next state and request/result capture
  always_comb begin
    estado_d  = estado_q;
    op_d      = op_q;
    end_d     = end_q;
    dados_d   = dados_q;
    escrita_d = escrita_q;
    saida_d   = saida_q;
    erro_d    = erro_q;
    unique case (estado_q)
      OCIOSO: begin
        if (bus.Iniciar) begin
          op_d    = op_in;
          end_d   = bus.Endereco;
          dados_d = bus.DadosEntrada[15:0];
          erro_d  = 1'b0;
          if (desalinhado(op_in,
                          bus.Endereco[1:0])) begin
            erro_d   = 1'b1;
            estado_d = CONCLUIDO;
          end else if (op_in == OP_SW) begin
            escrita_d = bus.DadosEntrada;
            estado_d  = ESCRITA;
          end else begin
            estado_d = LEITURA;
          end
        end
      end
      LEITURA: begin
        if (eh_escrita(op_q)) begin
          escrita_d = mescla;
          estado_d  = ESCRITA;
        end else begin
          saida_d  = carga;
          estado_d = CONCLUIDO;
        end
      end
      ESCRITA:   estado_d = CONCLUIDO;
      CONCLUIDO: estado_d = OCIOSO;
    endcase
  end

  // state and request registers
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      estado_q  <= OCIOSO;
      op_q      <= OP_LW;
      end_q     <= '0;
      dados_q   <= '0;
      escrita_q <= '0;
      saida_q   <= '0;
      erro_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      op_q      <= op_d;
      end_q     <= end_d;
      dados_q   <= dados_d;
      escrita_q <= escrita_d;
      saida_q   <= saida_d;
      erro_q    <= erro_d;
    end
  end

  assign bus.Ocupado         = estado_q != OCIOSO;
  assign bus.Pronto          = estado_q == CONCLUIDO;
  assign bus.MemRead         = estado_q == LEITURA;
  assign bus.MemWrite        = estado_q == ESCRITA;
  assign bus.MemEndereco     = {end_q[31:2], 2'b00};
  assign bus.MemDadosEscrita = escrita_q;
  assign bus.DadosSaida      = saida_q;
  assign bus.ErroAlinhamento = erro_q;

endmodule

// File: tb/tb_unidade_acesso_memoria.sv
// Bench for unidade_acesso_memoria: directed cases
// plus random traffic against a byte-level model.
module tb_unidade_acesso_memoria;
  import pacote_memoria::*;

  logic Clock = 1'b0;
  logic ResetN;
  always #5 Clock = ~Clock;

  unidade_acesso_memoria_if bus();

  unidade_acesso_memoria dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus)
  );

  // word memory; an undriven bus reads as a
  // poison pattern so stray sampling shows up
  logic [31:0] mem [0:1023];
  assign bus.MemDadosLidos = bus.MemRead ?
    mem[bus.MemEndereco[11:2]] : 32'hBAD0_BAD0;
  always @(posedge Clock)
    if (bus.MemWrite)
      mem[bus.MemEndereco[11:2]] <= bus.MemDadosEscrita;

  int n_escritas = 0;
  int n_leituras = 0;
  int n_pronto   = 0;
  int n_conflito = 0;
  logic [31:0] ult_end_escrita = '0;

  always @(posedge Clock) begin
    if (bus.MemWrite) begin
      n_escritas++;
      ult_end_escrita = bus.MemEndereco;
    end
    if (bus.MemRead) n_leituras++;
    if (bus.MemRead && bus.MemWrite) n_conflito++;
  end

  always @(negedge Clock)
    if (bus.Pronto) n_pronto++;

  // reference: byte-addressed memory + last load
  logic [7:0]  ref_mem [0:4095];
  logic [31:0] ref_saida;

  int n_vetores = 0;
  int n_erros   = 0;

  task automatic verifica(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] esp
  );
    n_vetores++;
    if (obs !== esp) begin
      n_erros++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, esp);
    end
  endtask

  function automatic logic [31:0] ref_palavra(
    input logic [31:0] a
  );
    int b;
    b = int'({a[11:2], 2'b00});
    return {ref_mem[b+3], ref_mem[b+2],
            ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic poke(
    input logic [31:0] a,
    input logic [31:0] w
  );
    int b;
    b = int'({a[11:2], 2'b00});
    mem[a[11:2]] = w;
    for (int i = 0; i < 4; i++)
      ref_mem[b+i] = w[8*i +: 8];
  endtask

  task automatic verifica_reset();
    verifica("rst_ocupado", bus.Ocupado, 0);
    verifica("rst_pronto", bus.Pronto, 0);
    verifica("rst_saida", bus.DadosSaida, 0);
    verifica("rst_erro", bus.ErroAlinhamento, 0);
    verifica("rst_memread", bus.MemRead, 0);
    verifica("rst_memwrite", bus.MemWrite, 0);
    verifica("rst_memend", bus.MemEndereco, 0);
    verifica("rst_memdados",
             bus.MemDadosEscrita, 0);
  endtask

  task automatic executar(
    input op_t         op,
    input logic [31:0] a,
    input logic [31:0] d
  );
    int tam, lat_esp, k, w0, r0, n_wr, n_rd;
    logic desal, carga, assinado;
    logic [31:0] v;
    tam = (op == OP_LW || op == OP_SW) ? 4 :
          (op == OP_LH || op == OP_LHU ||
           op == OP_SH) ? 2 : 1;
    carga    = op inside {OP_LW, OP_LH, OP_LHU,
                          OP_LB, OP_LBU};
    assinado = op inside {OP_LH, OP_LB};
    desal    = (a % tam) != 0;
    n_wr = 0;
    n_rd = 0;
    if (desal) begin
      lat_esp = 0;
    end else if (carga) begin
      lat_esp = 1;
      n_rd    = 1;
      v = 0;
      for (int i = 0; i < tam; i++)
        v = v | (32'(ref_mem[int'(a)+i]) << (8*i));
      if (tam < 4 && assinado && v[8*tam-1])
        v = v | (32'hFFFF_FFFF << (8*tam));
      ref_saida = v;
    end else begin
      lat_esp = (tam == 4) ? 1 : 2;
      n_wr    = 1;
      n_rd    = (tam == 4) ? 0 : 1;
      for (int i = 0; i < tam; i++)
        ref_mem[int'(a)+i] = d[8*i +: 8];
    end
    @(negedge Clock);
    bus.Iniciar      = 1'b1;
    bus.Operacao     = op;
    bus.Endereco     = a;
    bus.DadosEntrada = d;
    w0 = n_escritas;
    r0 = n_leituras;
    @(posedge Clock);
    #1;
    bus.Iniciar      = 1'b0;
    bus.Operacao     = 3'($urandom);
    bus.Endereco     = $urandom;
    bus.DadosEntrada = $urandom;
    k = 0;
    while (!bus.Pronto && k < 6) begin
      @(posedge Clock);
      #1;
      k++;
    end
    verifica("latencia", k, lat_esp);
    verifica("erro", bus.ErroAlinhamento, desal);
    verifica("saida", bus.DadosSaida, ref_saida);
    verifica("escritas", n_escritas - w0, n_wr);
    verifica("leituras", n_leituras - r0, n_rd);
    if (n_wr == 1) begin
      verifica("end_escrita", ult_end_escrita,
               {a[31:2], 2'b00});
      verifica("memoria", mem[a[11:2]],
               ref_palavra(a));
    end
    @(posedge Clock);
    #1;
    verifica("ocioso", bus.Ocupado, 0);
  endtask

  initial begin
    int p0, w0;
    op_t op;
    logic [31:0] a;
    ResetN           = 1'b0;
    bus.Iniciar      = 1'b0;
    bus.Operacao     = '0;
    bus.Endereco     = '0;
    bus.DadosEntrada = '0;
    ref_saida        = '0;
    for (int i = 0; i < 1024; i++)
      poke(32'(i*4), $urandom);
    #12;
    verifica_reset();
    @(negedge Clock);
    ResetN = 1'b1;

    // word round trip
    executar(OP_SW, 32'h10, 32'hDEAD_BEEF);
    executar(OP_LW, 32'h10, 32'h0);
    verifica("lw10", bus.DadosSaida, 32'hDEAD_BEEF);

    // signed/unsigned sub-word loads
    poke(32'h20, 32'h80FF_7F01);
    executar(OP_LB, 32'h23, 0);
    verifica("lb23", bus.DadosSaida, 32'hFFFF_FF80);
    executar(OP_LBU, 32'h23, 0);
    verifica("lbu23", bus.DadosSaida, 32'h0000_0080);
    executar(OP_LB, 32'h21, 0);
    verifica("lb21", bus.DadosSaida, 32'h0000_007F);
    executar(OP_LH, 32'h22, 0);
    verifica("lh22", bus.DadosSaida, 32'hFFFF_80FF);

    // byte read-modify-write
    poke(32'h30, 32'h1122_3344);
    executar(OP_SB, 32'h31, 32'h5566_77AA);
    verifica("sb31", mem[12], 32'h1122_AA44);

    // misaligned requests
    executar(OP_LW, 32'h12, 0);
    executar(OP_SH, 32'h15, 32'h1234_5678);

    // request while busy is dropped
    poke(32'h50, 32'h0BAD_CAFE);
    @(negedge Clock);
    bus.Iniciar  = 1'b1;
    bus.Operacao = OP_LW;
    bus.Endereco = 32'h50;
    p0 = n_pronto;
    w0 = n_escritas;
    @(posedge Clock);
    #1;
    bus.Iniciar = 1'b0;
    verifica("busy_ocupado", bus.Ocupado, 1);
    @(negedge Clock);
    bus.Iniciar      = 1'b1;
    bus.Operacao     = OP_SW;
    bus.Endereco     = 32'h54;
    bus.DadosEntrada = 32'h1234_5678;
    @(posedge Clock);
    #1;
    bus.Iniciar = 1'b0;
    ref_saida   = 32'h0BAD_CAFE;
    verifica("busy_pronto", bus.Pronto, 1);
    verifica("busy_ocup_fim", bus.Ocupado, 1);
    verifica("busy_saida", bus.DadosSaida, ref_saida);
    @(posedge Clock);
    #1;
    verifica("busy_livre", bus.Ocupado, 0);
    repeat (3) @(posedge Clock);
    #1;
    verifica("busy_npronto", n_pronto - p0, 1);
    verifica("busy_nescr", n_escritas - w0, 0);
    verifica("busy_mem54", mem[21],
             ref_palavra(32'h54));

    // reset in the middle of an SB
    poke(32'h40, 32'hCAFE_F00D);
    @(negedge Clock);
    bus.Iniciar      = 1'b1;
    bus.Operacao     = OP_SB;
    bus.Endereco     = 32'h41;
    bus.DadosEntrada = 32'h77;
    p0 = n_pronto;
    w0 = n_escritas;
    @(posedge Clock);
    #1;
    bus.Iniciar = 1'b0;
    verifica("rst_sb_leit", bus.MemRead, 1);
    #2;
    ResetN = 1'b0;
    #1;
    verifica("rst_sb_rd0", bus.MemRead, 0);
    verifica("rst_sb_wr0", bus.MemWrite, 0);
    repeat (2) @(negedge Clock);
    ResetN    = 1'b1;
    ref_saida = '0;
    #1;
    verifica_reset();
    verifica("rst_sb_mem", mem[16], 32'hCAFE_F00D);
    verifica("rst_sb_pronto", n_pronto - p0, 0);
    verifica("rst_sb_nescr", n_escritas - w0, 0);
    executar(OP_LW, 32'h40, 0);

    // random traffic
    for (int n = 0; n < 150; n++) begin
      op = op_t'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 255));
      executar(op, a, $urandom);
    end

    verifica("conflito_rw", n_conflito, 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vetores, n_erros);
    $finish;
  end

endmodule

// File: doc/unidade_acesso_memoria.md
# unidade_acesso_memoria

Load/store initiator sitting between the processor's memory stage and the word-only data memory (1024 × 32-bit words, write on rising edge when MemWrite=1, combinational read when MemRead=1 and high-Z otherwise). It accepts one request at a time: word, halfword or byte loads and stores, signed or unsigned. Sub-word stores are performed as read-modify-write over the word interface. A small FSM sequences each memory access and signals completion with a one-cycle Pronto pulse.

## Interface
Parameters:
- none; widths are fixed at 32-bit address and data.

Ports:
- Clock  in  1  single clock; all state updates on rising edge
- ResetN  in  1  reset, asynchronous, active-low
- Iniciar  in  1  request strobe; accepted only in OCIOSO
- Operacao  in  3  LW=000, LH=001, LHU=010, LB=011, LBU=100, SW=101, SH=110, SB=111
- Endereco  in  32  byte address of the request
- DadosEntrada  in  32  store data; low 16/8 bits used for SH/SB
- Ocupado  out  1  request in progress; Iniciar ignored while high
- Pronto  out  1  one-cycle completion pulse
- DadosSaida  out  32  extended load result
- ErroAlinhamento  out  1  misaligned request; valid while Pronto=1
- MemEndereco  out  32  word-aligned address {EnderecoReg[31:2],2'b00}
- MemDadosEscrita  out  32  word to write
- MemWrite  out  1  write enable to data memory
- MemRead  out  1  read enable to data memory
- MemDadosLidos  in  32  combinational read data from data memory

## Operation
- States: OCIOSO, LEITURA, ESCRITA, CONCLUIDO.
- Acceptance: in OCIOSO with Iniciar=1, register Operacao, Endereco and DadosEntrada, and clear ErroAlinhamento.
- Alignment rules:
  - word operations require Endereco[1:0]=00
  - halfword operations require Endereco[0]=0
  - byte operations are always aligned
- Misaligned request: go OCIOSO→CONCLUIDO with ErroAlinhamento=1. No MemRead or MemWrite is asserted, and DadosSaida is unchanged.
- Transitions out of OCIOSO:
  - load → LEITURA
  - SW → ESCRITA
  - SH/SB → LEITURA
- LEITURA:
  - MemRead=1; MemDadosLidos is sampled at the edge.
  - Loads: extract the lane, extend it into DadosSaida, then →CONCLUIDO.
  - SH/SB: capture the word, then →ESCRITA.
- ESCRITA: MemWrite=1 for exactly one cycle, then →CONCLUIDO.
  - SW writes DadosEntrada.
  - SH/SB write the captured word with only the addressed lane replaced.
- CONCLUIDO: Pronto=1, then →OCIOSO.
- Lanes are little-endian:
  - byte at bits [8*Endereco[1:0]+7 : 8*Endereco[1:0]]
  - halfword at [16*Endereco[1]+15 : 16*Endereco[1]]
- Extension: LH/LB sign-extend; LHU/LBU zero-extend.
- MemRead and MemWrite are never high simultaneously and are low in OCIOSO and CONCLUIDO.
- DadosSaida holds the last load result until the next successful load; stores do not alter it.

## Timing
- E0 is the acceptance edge.
- Pronto is high in the cycle after:
  - E1 for loads and SW
  - E2 for SH/SB
  - E0 for misaligned requests
- Ocupado = (state ≠ OCIOSO), so a new request is possible at the edge ending CONCLUIDO+1 at the earliest. Back-to-back throughput is one request per 3 cycles for loads/SW and 4 cycles for SH/SB.
- Iniciar held high continuously re-requests on every return to OCIOSO.
- Iniciar while Ocupado is ignored, not queued.
- Reset values: state=OCIOSO, Ocupado=0, Pronto=0, DadosSaida=0, ErroAlinhamento=0, MemRead=0, MemWrite=0, MemEndereco=0, MemDadosEscrita=0.
- Reset mid-operation:
  - MemWrite/MemRead drop immediately (decoded from state)
  - no Pronto is issued
  - the memory word is untouched unless the write edge already occurred.
- Memory control and address outputs are decoded from registered state and request, so they are glitch-free within the cycle.

## Structure
- Package pacote_memoria holds:
  - operation encodings OP_LW…OP_SB
  - state encodings
  - helpers for the alignment check
- Sub-module alinhador_bytes is combinational and handles lane extraction with extension (loads) and lane merge (stores). It is shared by the LEITURA and ESCRITA paths.
- FSM, request registers and output registers live in the top module.

## Test plan
- Word round trip: SW 0xDEADBEEF @0x10 → MemWrite pulse with MemEndereco=0x10, Pronto after 2 cycles. Then LW @0x10 → DadosSaida=0xDEADBEEF, ErroAlinhamento=0.
- Signed and unsigned byte loads: memory word 0x80FF7F01 @0x20.
  - LB @0x23 → 0xFFFFFF80; LBU @0x23 → 0x00000080
  - LB @0x21 → 0x0000007F; LH @0x22 → 0xFFFF80FF
- Byte RMW: memory word 0x11223344 @0x30. SB 0xAA @0x31 → one read cycle, then one write of 0x1122AA44. Pronto at E2 and exactly one MemWrite pulse.
- Misalignment: LW @0x12 and SH @0x15 → Pronto the cycle after acceptance with ErroAlinhamento=1, no MemRead/MemWrite, DadosSaida unchanged.
- Busy handling: Iniciar pulsed during LEITURA of an LW → ignored. Exactly one Pronto, and Ocupado stays high until after CONCLUIDO.
- Reset mid-SB: ResetN low during LEITURA → MemRead drops asynchronously, no write occurs and the memory word is unchanged. After release, all outputs are at their reset values and a new LW completes normally.
